// File: rtl/bk_nibble_serial_adder.sv
// Wide adder that streams operands through one 4-bit Brent-Kung core, one nibble
// per cycle LSB first, with valid/ready handshakes on both sides.

module bk_add4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [4:0] o_sum
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic       w_g10, w_p10, w_g32, w_p32, w_g20, w_p20, w_g30, w_p30;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Brent-Kung prefix tree: pairwise groups, then the root, then the back-fill for bit 2
    assign w_g10 = w_g[1] | (w_p[1] & w_g[0]);
    assign w_p10 = w_p[1] & w_p[0];
    assign w_g32 = w_g[3] | (w_p[3] & w_g[2]);
    assign w_p32 = w_p[3] & w_p[2];
    assign w_g30 = w_g32 | (w_p32 & w_g10);
    assign w_p30 = w_p32 & w_p10;
    assign w_g20 = w_g[2] | (w_p[2] & w_g10);
    assign w_p20 = w_p[2] & w_p10;

    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g10 | (w_p10 & i_cin);
    assign w_c[3] = w_g20 | (w_p20 & i_cin);
    assign w_c[4] = w_g30 | (w_p30 & i_cin);

    assign o_sum = {w_c[4], w_p ^ w_c[3:0]};
endmodule

module bk_nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("bk_nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_cout;
    logic             r_ovf;
    logic [4:0]       w_core;
    logic             w_accept;
    logic             w_last;

    bk_add4 u_core (
        .i_a   (r_a_sh[3:0]),
        .i_b   (r_b_sh[3:0]),
        .i_cin (r_carry),
        .o_sum (w_core)
    );

    // Accept in DONE only alongside the output handshake so a result is never overwritten
    assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    assign out_valid = (r_state == S_DONE);
    assign w_accept  = in_valid & in_ready;
    assign w_last    = (r_idx == IDX_W'(NIBBLES - 1));
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_sh  <= a;
                r_b_sh  <= b;
                r_carry <= cin;
                r_idx   <= '0;
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= b[WIDTH-1];
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) r_state <= S_RUN;
                end
                S_RUN: begin
                    // Result nibbles enter at the top so the sum is aligned after NIBBLES passes
                    r_sum   <= {w_core[3:0], r_sum[WIDTH-1:4]};
                    r_carry <= w_core[4];
                    r_a_sh  <= {4'b0000, r_a_sh[WIDTH-1:4]};
                    r_b_sh  <= {4'b0000, r_b_sh[WIDTH-1:4]};
                    r_idx   <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_cout  <= w_core[4];
                        r_ovf   <= (r_a_msb == r_b_msb) & (w_core[3] != r_a_msb);
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) r_state <= w_accept ? S_RUN : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bk_nibble_serial_adder.sv
// Randomized and directed checks of bk_nibble_serial_adder (16- and 8-bit instances)
// against an arithmetic reference model.

module tb_bk_nibble_serial_adder;
    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, cin, cout, ovf;
    logic [15:0] a, b, sum;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;
    int          checks;
    int          failures;
    int          cyc;

    bk_nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    bk_nibble_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: {ovf, cout, sum} from plain integer addition and sign rules
    function automatic logic [17:0] model16(input logic [15:0] ma, input logic [15:0] mb,
                                            input logic mc);
        logic [16:0] t;
        logic        v;
        t = 17'(ma) + 17'(mb) + 17'(mc);
        v = (ma[15] == mb[15]) && (t[15] != ma[15]);
        return {v, t};
    endfunction

    function automatic logic [9:0] model8(input logic [7:0] ma, input logic [7:0] mb,
                                          input logic mc);
        logic [8:0] t;
        logic       v;
        t = 9'(ma) + 9'(mb) + 9'(mc);
        v = (ma[7] == mb[7]) && (t[7] != ma[7]);
        return {v, t};
    endfunction

    // Drives one operation, scrambles inputs after acceptance, holds backpressure, then handshakes
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                          input int hold, output int lat, output logic [15:0] s,
                          output logic co, output logic ov, output bit to, output bit stable);
        int guard;
        to = 1'b0;
        stable = 1'b1;
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        guard = 0;
        #1;
        while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        if (!in_ready) to = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        if (!out_valid) to = 1'b1;
        s = sum; co = cout; ov = ovf;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || sum !== s || cout !== co || ovf !== ov) stable = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0;
        in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b, want 0/0000/0/0",
                     out_valid, sum, cout, ovf);
        end
        #3 rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || in_ready8 !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b/%b, want 1/1", in_ready, in_ready8);
        end
    endtask

    task automatic test_directed();
        logic [15:0] d_a [4];
        logic [15:0] d_b [4];
        logic        d_c [4];
        logic [17:0] exp;
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        bit          to, st;
        d_a[0] = 16'h1234; d_b[0] = 16'h0FCD; d_c[0] = 1'b0;
        d_a[1] = 16'hFFFF; d_b[1] = 16'h0001; d_c[1] = 1'b0;
        d_a[2] = 16'h7FFF; d_b[2] = 16'h0001; d_c[2] = 1'b0;
        d_a[3] = 16'h0000; d_b[3] = 16'h0000; d_c[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = model16(d_a[i], d_b[i], d_c[i]);
            run_op(d_a[i], d_b[i], d_c[i], 0, lat, s, co, ov, to, st);
            checks++;
            if (to || lat != 4) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got %0d (timeout=%0b), want 4", i, lat, to);
            end
            checks++;
            if ({ov, co, s} !== exp) begin
                failures++;
                $display("FAIL directed_result[%0d]: got ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h",
                         i, ov, co, s, exp[17], exp[16], exp[15:0]);
            end
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL directed_idle[%0d]: got valid=%b ready=%b, want 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        bit          to, st;
        run_op(16'h8000, 16'h8000, 1'b0, 5, lat, s, co, ov, to, st);
        checks++;
        if (to || !st) begin
            failures++;
            $display("FAIL backpressure_stable: got stable=%0b timeout=%0b, want 1/0", st, to);
        end
        checks++;
        if (s !== 16'h0000 || co !== 1'b1 || ov !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_result: got sum=%h cout=%b ovf=%b, want 0000/1/1", s, co, ov);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_single: got out_valid=%b after handshake, want 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic [15:0] ra, rb, s;
        logic        rc, co, ov;
        logic [17:0] exp;
        int          lat, hold;
        bit          to, st;
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            if (i % 5 == 0) rb = ~ra;
            hold = int'($urandom_range(0, 3));
            exp = model16(ra, rb, rc);
            run_op(ra, rb, rc, hold, lat, s, co, ov, to, st);
            checks++;
            if (to || lat != 4 || !st || {ov, co, s} !== exp) begin
                failures++;
                $display("FAIL random[%0d] a=%h b=%h cin=%b: got lat=%0d stable=%0b ovf=%b cout=%b sum=%h, want lat=4 stable=1 ovf=%b cout=%b sum=%h",
                         i, ra, rb, rc, lat, st, ov, co, s, exp[17], exp[16], exp[15:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, lat;
        a = 16'h1234; b = 16'h0FCD; cin = 1'b0; in_valid = 1'b1;
        #1;
        lat = 0;
        while (!in_ready && lat < 50) begin @(posedge clk); #1; lat++; end
        @(posedge clk); #1;
        acc1 = cyc;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat != 4 || sum !== 16'h2201) begin
            failures++;
            $display("FAIL b2b_first: got lat=%0d sum=%h, want 4/2201", lat, sum);
        end
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready_in_done: got in_ready=%b, want 1", in_ready);
        end
        @(posedge clk); #1;
        acc2 = cyc;
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (acc2 - acc1 != 5 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_spacing: got spacing=%0d out_valid=%b, want 5/0", acc2 - acc1, out_valid);
        end
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat != 4 || sum !== 16'hFFFF || cout !== 1'b1 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second: got lat=%0d sum=%h cout=%b ovf=%b, want 4/FFFF/1/0",
                     lat, sum, cout, ovf);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        bit          to, st;
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
        #1;
        lat = 0;
        while (!in_ready && lat < 50) begin @(posedge clk); #1; lat++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_assert: got valid=%b ready=%b, want 0/1", out_valid, in_ready);
        end
        #3 rst_n = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0) begin
            failures++;
            $display("FAIL reset_mid_release: got valid=%b ready=%b sum=%h, want 0/1/0000",
                     out_valid, in_ready, sum);
        end
        run_op(16'h0F0F, 16'h00F1, 1'b1, 0, lat, s, co, ov, to, st);
        checks++;
        if (to || lat != 4 || s !== 16'h1001 || co !== 1'b0 || ov !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_next: got lat=%0d sum=%h cout=%b ovf=%b, want 4/1001/0/0",
                     lat, s, co, ov);
        end
    endtask

    task automatic test_width8();
        logic [7:0] ra, rb;
        logic       rc;
        logic [9:0] exp;
        int         lat, guard;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                ra = 8'hC8; rb = 8'h64; rc = 1'b0;
            end else begin
                ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            end
            exp = model8(ra, rb, rc);
            a8 = ra; b8 = rb; cin8 = rc; in_valid8 = 1'b1;
            #1;
            guard = 0;
            while (!in_ready8 && guard < 50) begin @(posedge clk); #1; guard++; end
            @(posedge clk); #1;
            in_valid8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom);
            lat = 0;
            while (!out_valid8 && lat < 50) begin @(posedge clk); #1; lat++; end
            checks++;
            if (lat != 2 || {ovf8, cout8, sum8} !== exp) begin
                failures++;
                $display("FAIL width8[%0d] a=%h b=%h cin=%b: got lat=%0d ovf=%b cout=%b sum=%h, want lat=2 ovf=%b cout=%b sum=%h",
                         i, ra, rb, rc, lat, ovf8, cout8, sum8, exp[9], exp[8], exp[7:0]);
            end
            out_ready8 = 1'b1;
            @(posedge clk); #1;
            out_ready8 = 1'b0;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_width8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
